// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter sharing one FMA-only FPU between NUM_REQ requesters.
// The FPU tag carries the requester index so results are routed back to their issuer.
module fpu_share_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int FLEN            = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TAG_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*3*FLEN-1:0]   req_operands_i,
    input  logic [NUM_REQ*4-1:0]        req_op_i,
    input  logic [NUM_REQ-1:0]          req_op_mod_i,
    input  logic [NUM_REQ*3-1:0]        req_rnd_mode_i,
    input  logic [NUM_REQ*3-1:0]        req_fmt_i,
    output logic [NUM_REQ-1:0]          resp_valid_o,
    input  logic [NUM_REQ-1:0]          resp_ready_i,
    output logic [FLEN-1:0]             resp_result_o,
    output logic [4:0]                  resp_status_o,
    output logic [3*FLEN-1:0]           fpu_operands_o,
    output logic [3:0]                  fpu_op_o,
    output logic                        fpu_op_mod_o,
    output logic [2:0]                  fpu_rnd_mode_o,
    output logic [2:0]                  fpu_fmt_o,
    output logic [TAG_WIDTH-1:0]        fpu_tag_o,
    output logic                        fpu_in_valid_o,
    input  logic                        fpu_in_ready_i,
    input  logic [FLEN-1:0]             fpu_result_i,
    input  logic [4:0]                  fpu_status_i,
    input  logic [TAG_WIDTH-1:0]        fpu_tag_i,
    input  logic                        fpu_out_valid_i,
    output logic                        fpu_out_ready_o,
    input  logic                        fpu_busy_i,
    output logic                        busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [TAG_WIDTH-1:0] locked_idx;
    logic [TAG_WIDTH-1:0] grant;
    logic [TAG_WIDTH-1:0] next_ptr;
    logic                 lock;
    logic [CNT_W-1:0]     cnt [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   cnt_nz;
    logic [NUM_REQ-1:0]   inc_vec;
    logic [NUM_REQ-1:0]   dec_vec;
    logic                 found;
    int unsigned          idx;
    logic                 in_valid;
    logic                 accept;
    logic                 out_ready;
    logic                 resp_fire;
    logic                 dec_underflow;

    always_comb begin
        eligible = '0;
        cnt_nz   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
            cnt_nz[i]   = (cnt[i] != '0);
        end
    end

    // A stalled request keeps its grant so the FPU sees stable inputs until accepted.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        if (lock) begin
            grant = locked_idx;
            found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = rr_ptr + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && eligible[idx]) begin
                    grant = TAG_WIDTH'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign in_valid = rst_ni && found;
    assign accept   = in_valid && fpu_in_ready_i;
    assign next_ptr = (grant == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign fpu_in_valid_o = in_valid;
    assign fpu_tag_o      = grant;

    always_comb begin
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_op_mod_o   = 1'b0;
        fpu_rnd_mode_o = '0;
        fpu_fmt_o      = '0;
        req_ready_o    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == TAG_WIDTH'(i)) begin
                fpu_operands_o = req_operands_i[i*3*FLEN +: 3*FLEN];
                fpu_op_o       = req_op_i[i*4 +: 4];
                fpu_op_mod_o   = req_op_mod_i[i];
                fpu_rnd_mode_o = req_rnd_mode_i[i*3 +: 3];
                fpu_fmt_o      = req_fmt_i[i*3 +: 3];
                req_ready_o[i] = in_valid && fpu_in_ready_i;
            end
        end
    end

    // Tags with no matching requester leave out_ready high so the result is dropped.
    always_comb begin
        resp_valid_o  = '0;
        out_ready     = 1'b1;
        dec_underflow = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (fpu_tag_i == TAG_WIDTH'(i)) begin
                resp_valid_o[i] = fpu_out_valid_i;
                out_ready       = resp_ready_i[i];
                dec_underflow   = fpu_out_valid_i && resp_ready_i[i] && !cnt_nz[i];
            end
        end
        if (!rst_ni) begin
            resp_valid_o  = '0;
            out_ready     = 1'b0;
            dec_underflow = 1'b0;
        end
    end

    assign fpu_out_ready_o = out_ready;
    assign resp_fire       = fpu_out_valid_i && out_ready && rst_ni;
    assign resp_result_o   = fpu_result_i;
    assign resp_status_o   = fpu_status_i;
    assign busy_o          = rst_ni && ((|cnt_nz) || fpu_busy_i || lock);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            inc_vec[i] = accept && (grant == TAG_WIDTH'(i));
            dec_vec[i] = resp_fire && (fpu_tag_i == TAG_WIDTH'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= next_ptr;
                lock   <= 1'b0;
            end else if (in_valid) begin
                lock       <= 1'b1;
                locked_idx <= grant;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_vec[i] && !inc_vec[i] && cnt_nz[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !dec_underflow);

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Randomised scoreboard bench for fpu_share_arbiter with an in-order FPU stub
// and a rule-level reference model of grant, credit and routing behaviour.
module tb_fpu_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FLEN    = 64;
    localparam int MAX_OUT = 2;
    localparam int TW      = 2;

    typedef struct {
        int               tag;
        logic [FLEN-1:0]  res;
        logic [4:0]       st;
        int               due;
    } fpu_e_t;

    typedef struct {
        logic [FLEN-1:0]  res;
        logic [4:0]       st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*3*FLEN-1:0] req_operands = '0;
    logic [NUM_REQ*4-1:0]      req_op = '0;
    logic [NUM_REQ-1:0]        req_op_mod = '0;
    logic [NUM_REQ*3-1:0]      req_rnd = '0;
    logic [NUM_REQ*3-1:0]      req_fmt = '0;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready = '0;
    logic [FLEN-1:0]           resp_result;
    logic [4:0]                resp_status;
    logic [3*FLEN-1:0]         fpu_operands;
    logic [3:0]                fpu_op;
    logic                      fpu_op_mod;
    logic [2:0]                fpu_rnd;
    logic [2:0]                fpu_fmt;
    logic [TW-1:0]             fpu_tag;
    logic                      fpu_in_valid;
    logic                      fpu_in_ready = 1'b0;
    logic [FLEN-1:0]           fpu_result = '0;
    logic [4:0]                fpu_status = '0;
    logic [TW-1:0]             fpu_tag_in = '0;
    logic                      fpu_out_valid = 1'b0;
    logic                      fpu_out_ready;
    logic                      fpu_busy = 1'b0;
    logic                      busy;

    fpu_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .FLEN(FLEN),
        .MAX_OUTSTANDING(MAX_OUT),
        .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_operands_i(req_operands),
        .req_op_i(req_op),
        .req_op_mod_i(req_op_mod),
        .req_rnd_mode_i(req_rnd),
        .req_fmt_i(req_fmt),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_result_o(resp_result),
        .resp_status_o(resp_status),
        .fpu_operands_o(fpu_operands),
        .fpu_op_o(fpu_op),
        .fpu_op_mod_o(fpu_op_mod),
        .fpu_rnd_mode_o(fpu_rnd),
        .fpu_fmt_o(fpu_fmt),
        .fpu_tag_o(fpu_tag),
        .fpu_in_valid_o(fpu_in_valid),
        .fpu_in_ready_i(fpu_in_ready),
        .fpu_result_i(fpu_result),
        .fpu_status_i(fpu_status),
        .fpu_tag_i(fpu_tag_in),
        .fpu_out_valid_i(fpu_out_valid),
        .fpu_out_ready_o(fpu_out_ready),
        .fpu_busy_i(fpu_busy),
        .busy_o(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    int cnt [NUM_REQ];
    int rr   = 0;
    bit lock = 1'b0;
    int lidx = 0;
    fpu_e_t pipe [$];
    exp_t   sb [NUM_REQ][$];
    int     glog [$];

    // stimulus knobs
    int p_new = 0, p_in = 100, p_resp = 100, p_busy = 0, lat_max = 2;
    logic [NUM_REQ-1:0] gen_mask  = '0;
    logic [NUM_REQ-1:0] resp_mask = '1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [FLEN-1:0] fpu_fn(input logic [3*FLEN-1:0] o, input logic [3:0] op);
        return o[FLEN-1:0] ^ {o[FLEN+31:FLEN], o[2*FLEN-1:FLEN+32]} ^ o[3*FLEN-1:2*FLEN]
               ^ {{(FLEN-4){1'b0}}, op};
    endfunction

    task automatic new_op(input int i);
        logic [3*FLEN-1:0] o;
        for (int w = 0; w < 6; w++) o[w*32 +: 32] = $urandom;
        req_operands[i*3*FLEN +: 3*FLEN] = o;
        req_op[i*4 +: 4]   = 4'($urandom);
        req_op_mod[i]      = 1'($urandom);
        req_rnd[i*3 +: 3]  = 3'($urandom);
        req_fmt[i*3 +: 3]  = 3'($urandom);
        req_valid[i]       = 1'b1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = '1;
        fpu_in_ready  = 1'b1;
        fpu_out_valid = 1'b1;
        fpu_tag_in    = '0;
        resp_ready    = '1;
        fpu_busy      = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_in_valid", fpu_in_valid, 0);
        check("rst_out_ready", fpu_out_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        cyc++;
        rst_n         = 1'b1;
        req_valid     = '0;
        fpu_out_valid = 1'b0;
        fpu_busy      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = 0;
            sb[i].delete();
        end
        rr   = 0;
        lock = 1'b0;
        lidx = 0;
        pipe.delete();
    endtask

    task automatic cycle();
        bit [NUM_REQ-1:0]   elig;
        logic [NUM_REQ-1:0] exp_rdy;
        int g, idx, t;
        bit found, acc, rf, exp_busy;
        fpu_e_t fe;
        exp_t   ee;
        for (int i = 0; i < NUM_REQ; i++)
            if (!req_valid[i] && gen_mask[i] && ($urandom_range(0, 99) < p_new)) new_op(i);
        fpu_in_ready = ($urandom_range(0, 99) < p_in);
        for (int i = 0; i < NUM_REQ; i++)
            resp_ready[i] = resp_mask[i] && ($urandom_range(0, 99) < p_resp);
        fpu_busy = ($urandom_range(0, 99) < p_busy);
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            fpu_out_valid = 1'b1;
            fpu_tag_in    = TW'(pipe[0].tag);
            fpu_result    = pipe[0].res;
            fpu_status    = pipe[0].st;
        end else begin
            fpu_out_valid = 1'b0;
            fpu_tag_in    = TW'($urandom);
            fpu_result    = {$urandom, $urandom};
            fpu_status    = 5'($urandom);
        end

        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) elig[i] = req_valid[i] && (cnt[i] < MAX_OUT);
        g = 0;
        found = 1'b0;
        if (lock) begin
            g = lidx;
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr + k) % NUM_REQ;
                if (!found && elig[idx]) begin
                    g = idx;
                    found = 1'b1;
                end
            end
        end
        check("in_valid", fpu_in_valid, found);
        if (found) begin
            exp_rdy = fpu_in_ready ? (NUM_REQ'(1) << g) : NUM_REQ'(0);
            check("tag", fpu_tag, g);
            check("operands", fpu_operands, req_operands[g*3*FLEN +: 3*FLEN]);
            check("ctrl", {fpu_op, fpu_op_mod, fpu_rnd, fpu_fmt},
                  {req_op[g*4 +: 4], req_op_mod[g], req_rnd[g*3 +: 3], req_fmt[g*3 +: 3]});
            check("req_ready", req_ready, exp_rdy);
        end
        check("resp_valid", resp_valid, fpu_out_valid ? (NUM_REQ'(1) << fpu_tag_in) : NUM_REQ'(0));
        if (fpu_out_valid) begin
            check("out_ready", fpu_out_ready, resp_ready[fpu_tag_in]);
            check("passthru", {resp_status, resp_result}, {fpu_status, fpu_result});
        end
        exp_busy = fpu_busy || lock;
        for (int i = 0; i < NUM_REQ; i++) if (cnt[i] != 0) exp_busy = 1'b1;
        check("busy", busy, exp_busy);

        acc = found && fpu_in_ready;
        if (acc) begin
            ee.res = fpu_fn(req_operands[g*3*FLEN +: 3*FLEN], req_op[g*4 +: 4]);
            ee.st  = {req_fmt[g*3 +: 2], req_rnd[g*3 +: 3]};
            t = cyc + int'($urandom_range(1, lat_max));
            if (pipe.size() > 0 && pipe[pipe.size()-1].due > t) t = pipe[pipe.size()-1].due;
            fe.tag = g;
            fe.res = ee.res;
            fe.st  = ee.st;
            fe.due = t;
            pipe.push_back(fe);
            sb[g].push_back(ee);
            cnt[g]++;
            rr   = (g + 1) % NUM_REQ;
            lock = 1'b0;
            glog.push_back(g);
        end else if (found) begin
            lock = 1'b1;
            lidx = g;
        end
        rf = fpu_out_valid && resp_ready[fpu_tag_in];
        if (rf) begin
            cnt[fpu_tag_in]--;
            pipe.delete(0);
        end

        @(posedge clk); #1;
        cyc++;
        if (acc) req_valid[g] = 1'b0;
    endtask

    // response monitor: pops the per-requester scoreboard whenever a result is handed over
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (resp_valid[i] && resp_ready[i]) begin
                        if (sb[i].size() == 0) begin
                            check("sb_unexpected_resp", i, 255);
                        end else begin
                            e = sb[i].pop_front();
                            check("sb_result", resp_result, e.res);
                            check("sb_status", resp_status, e.st);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int r0;
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        do_reset();

        // single requester
        glog.delete();
        new_op(1);
        repeat (8) cycle();
        check("single_grant", (glog.size() == 1) ? glog[0] : -1, 1);
        check("single_drain", sb[1].size(), 0);

        // fairness with all requesters continuously valid
        gen_mask = '1; p_new = 100; lat_max = 1;
        glog.delete();
        r0 = rr;
        repeat (16) cycle();
        check("rr_count", glog.size(), 16);
        for (int k = 0; k < glog.size(); k++) check("rr_order", glog[k], (r0 + k) % NUM_REQ);
        gen_mask = '0; p_new = 0;
        repeat (8) cycle();

        // stall lock
        do_reset();
        glog.delete();
        new_op(0); new_op(2);
        p_in = 0;
        repeat (3) cycle();
        p_in = 100;
        repeat (2) cycle();
        check("stall_first", (glog.size() > 0) ? glog[0] : -1, 0);
        check("stall_second", (glog.size() > 1) ? glog[1] : -1, 2);
        repeat (6) cycle();

        // credit limit on requester 3
        do_reset();
        glog.delete();
        resp_mask = 4'b0111;
        new_op(3); cycle();
        new_op(3); cycle();
        new_op(3); new_op(1); cycle();
        check("credit_skip", (glog.size() > 2) ? glog[2] : -1, 1);
        repeat (3) cycle();
        check("credit_block", glog.size(), 3);
        resp_mask = '1;
        repeat (8) cycle();
        check("credit_resume", (glog.size() > 3) ? glog[3] : -1, 3);
        repeat (6) cycle();

        // accept and response for the same requester in one cycle
        do_reset();
        glog.delete();
        lat_max = 1;
        new_op(0); cycle();
        new_op(0); cycle();
        repeat (4) cycle();
        check("simul_count", glog.size(), 2);

        // reset with operations in flight
        resp_mask = '0;
        new_op(0); new_op(1); new_op(2);
        repeat (4) cycle();
        do_reset();
        resp_mask = '1;
        cycle();
        glog.delete();
        new_op(3); new_op(0);
        cycle();
        check("post_reset_grant", (glog.size() > 0) ? glog[0] : -1, 0);
        repeat (4) cycle();

        // random traffic with a mid-run reset
        gen_mask = '1; p_new = 50; p_in = 70; p_resp = 75; lat_max = 4; p_busy = 10;
        repeat (1500) cycle();
        do_reset();
        repeat (1500) cycle();

        gen_mask = '0; p_new = 0; p_in = 100; p_resp = 100; p_busy = 0;
        repeat (40) cycle();
        for (int i = 0; i < NUM_REQ; i++) check("final_drain", sb[i].size(), 0);
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
